// File: rtl/median_window_gen_3x3.sv
// 3x3 window generator for the median filter: two line buffers feed a 3x3 shift window,
// and one fully populated window is emitted per interior pixel through a one-entry output register.
module median_window_gen_3x3 #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_pixel,
  input  logic                  in_sof,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic [9*DATA_W-1:0]   win_data,
  output logic                  win_eof
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]       col, cur_col;
  logic [RW-1:0]       row, cur_row;
  logic [DATA_W-1:0]   lb0 [IMG_W];
  logic [DATA_W-1:0]   lb1 [IMG_W];
  logic [DATA_W-1:0]   win [9];
  logic [DATA_W-1:0]   win_nxt [9];
  logic [9*DATA_W-1:0] win_flat;
  logic                accept, emit, last_pix;

  assign in_ready = !win_valid || win_ready;
  assign accept   = in_valid && in_ready;

  // in_sof overrides the counters so the pixel is treated as (0,0)
  always_comb begin
    cur_col  = in_sof ? '0 : col;
    cur_row  = in_sof ? '0 : row;
    emit     = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
    last_pix = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
  end

  always_comb begin
    win_nxt = win;
    for (int unsigned i = 0; i < 3; i++) begin
      win_nxt[3*i]   = win[3*i+1];
      win_nxt[3*i+1] = win[3*i+2];
    end
    win_nxt[2] = lb1[cur_col];
    win_nxt[5] = lb0[cur_col];
    win_nxt[8] = in_pixel;
  end

  always_comb begin
    win_flat = '0;
    for (int unsigned i = 0; i < 9; i++) begin
      win_flat[i*DATA_W +: DATA_W] = win_nxt[i];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[cur_col] <= lb0[cur_col];
      lb0[cur_col] <= in_pixel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (cur_col == COL_LAST) begin
        col <= '0;
        row <= (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
      end else begin
        col <= cur_col + CW'(1);
        row <= cur_row;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 9; i++) begin
        win[i] <= '0;
      end
    end else if (accept) begin
      win <= win_nxt;
    end
  end

  // accept implies the output slot is free or being popped this cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_valid <= 1'b0;
      win_data  <= '0;
      win_eof   <= 1'b0;
    end else if (accept && emit) begin
      win_valid <= 1'b1;
      win_data  <= win_flat;
      win_eof   <= last_pix;
    end else if (win_ready) begin
      win_valid <= 1'b0;
      win_eof   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_median_window_gen_3x3.sv
// Directed bench for median_window_gen_3x3 on a 5x4 image.
`timescale 1ns/1ps
module tb_median_window_gen_3x3;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_pixel = '0;
  logic          in_sof = 1'b0;
  logic          win_valid;
  logic          win_ready = 1'b1;
  logic [9*DW-1:0] win_data;
  logic          win_eof;

  typedef struct packed {
    logic [9*DW-1:0] d;
    logic            eof;
  } win_t;

  win_t got[$];
  int   pass_cnt = 0;
  int   check_cnt = 0;

  median_window_gen_3x3 #(.DATA_W(DW), .IMG_W(5), .IMG_H(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel), .in_sof(in_sof),
    .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data), .win_eof(win_eof)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && win_valid && win_ready) got.push_back('{d: win_data, eof: win_eof});
  end

  // window from pixel (r,c) of a frame whose pixel values are base + r*5 + c
  function automatic logic [9*DW-1:0] exp_win(input int base, input int r, input int c);
    logic [9*DW-1:0] w;
    int v;
    w = '0;
    for (int k = 0; k < 9; k++) begin
      v = base + (r - 2 + k / 3) * 5 + (c - 2 + k % 3);
      w[k*DW +: DW] = v[DW-1:0];
    end
    return w;
  endfunction

  task automatic push(input int p, input logic sof);
    int n = 0;
    in_valid = 1'b1;
    in_pixel = p[DW-1:0];
    in_sof   = sof;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check_cnt++;
      $display("FAIL push_timeout pixel=%0d in_ready=%b required 1", p, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    check_cnt++;
    if (win_valid !== 1'b0) $display("FAIL reset_win_valid got=%b exp=0", win_valid);
    else pass_cnt++;
    check_cnt++;
    if (win_data !== '0) $display("FAIL reset_win_data got=%h exp=0", win_data);
    else pass_cnt++;
    check_cnt++;
    if (win_eof !== 1'b0) $display("FAIL reset_win_eof got=%b exp=0", win_eof);
    else pass_cnt++;
    check_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    else pass_cnt++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_frame();
    logic [9*DW-1:0] first, last;
    first = {8'd12, 8'd11, 8'd10, 8'd7, 8'd6, 8'd5, 8'd2, 8'd1, 8'd0};
    last  = {8'd19, 8'd18, 8'd17, 8'd14, 8'd13, 8'd12, 8'd9, 8'd8, 8'd7};
    got.delete();
    win_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      push(i, i == 0);
      if (i == 11) begin
        check_cnt++;
        if (win_valid !== 1'b0) $display("FAIL sf_no_early_valid got=%b exp=0", win_valid);
        else pass_cnt++;
      end
      if (i == 12) begin
        check_cnt++;
        if (win_valid !== 1'b1 || win_data !== first)
          $display("FAIL sf_latency valid=%b data=%h exp valid=1 data=%h", win_valid, win_data, first);
        else pass_cnt++;
      end
    end
    drain();
    check_cnt++;
    if (got.size() !== 6) $display("FAIL sf_count got=%0d exp=6", got.size());
    else pass_cnt++;
    if (got.size() == 6) begin
      check_cnt++;
      if (got[5].d !== last || got[5].eof !== 1'b1)
        $display("FAIL sf_last data=%h eof=%b exp data=%h eof=1", got[5].d, got[5].eof, last);
      else pass_cnt++;
      for (int j = 0; j < 5; j++) begin
        check_cnt++;
        if (got[j].d !== exp_win(0, 2 + j / 3, 2 + j % 3) || got[j].eof !== 1'b0)
          $display("FAIL sf_win%0d data=%h eof=%b exp data=%h eof=0", j, got[j].d, got[j].eof,
                   exp_win(0, 2 + j / 3, 2 + j % 3));
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [9*DW-1:0] first;
    first = exp_win(0, 2, 2);
    got.delete();
    win_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) push(i, i == 0);
      end
      begin
        int n = 0;
        @(negedge clk);
        while (!win_valid && n < 100) begin
          @(negedge clk);
          n++;
        end
        for (int k = 0; k < 10; k++) begin
          check_cnt++;
          if (in_ready !== 1'b0 || win_valid !== 1'b1 || win_data !== first)
            $display("FAIL bp_hold%0d in_ready=%b valid=%b data=%h exp 0/1/%h",
                     k, in_ready, win_valid, win_data, first);
          else pass_cnt++;
          @(negedge clk);
        end
        @(posedge clk); #1;
        win_ready = 1'b1;
      end
    join
    drain();
    check_cnt++;
    if (got.size() !== 6) $display("FAIL bp_count got=%0d exp=6", got.size());
    else pass_cnt++;
    for (int j = 0; j < 6 && j < got.size(); j++) begin
      check_cnt++;
      if (got[j].d !== exp_win(0, 2 + j / 3, 2 + j % 3) || got[j].eof !== (j == 5))
        $display("FAIL bp_win%0d data=%h eof=%b exp data=%h eof=%b", j, got[j].d, got[j].eof,
                 exp_win(0, 2 + j / 3, 2 + j % 3), j == 5);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [9*DW-1:0] b_first;
    b_first = {8'd112, 8'd111, 8'd110, 8'd107, 8'd106, 8'd105, 8'd102, 8'd101, 8'd100};
    got.delete();
    win_ready = 1'b1;
    for (int i = 0; i < 20; i++) push(i, 1'b0);
    for (int i = 0; i < 20; i++) push(100 + i, i == 0);
    drain();
    check_cnt++;
    if (got.size() !== 12) $display("FAIL b2b_count got=%0d exp=12", got.size());
    else pass_cnt++;
    if (got.size() == 12) begin
      check_cnt++;
      if (got[6].d !== b_first) $display("FAIL b2b_first_b got=%h exp=%h", got[6].d, b_first);
      else pass_cnt++;
      for (int j = 0; j < 12; j++) begin
        check_cnt++;
        if (got[j].d !== exp_win(j < 6 ? 0 : 100, 2 + (j % 6) / 3, 2 + j % 3) ||
            got[j].eof !== (j % 6 == 5))
          $display("FAIL b2b_win%0d data=%h eof=%b exp data=%h eof=%b", j, got[j].d, got[j].eof,
                   exp_win(j < 6 ? 0 : 100, 2 + (j % 6) / 3, 2 + j % 3), j % 6 == 5);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_sof_abort();
    got.delete();
    win_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(50 + i, i == 0);
    for (int i = 0; i < 20; i++) push(200 + i, i == 0);
    drain();
    check_cnt++;
    if (got.size() !== 6) $display("FAIL sof_count got=%0d exp=6", got.size());
    else pass_cnt++;
    for (int j = 0; j < 6 && j < got.size(); j++) begin
      check_cnt++;
      if (got[j].d !== exp_win(200, 2 + j / 3, 2 + j % 3) || got[j].eof !== (j == 5))
        $display("FAIL sof_win%0d data=%h eof=%b exp data=%h eof=%b", j, got[j].d, got[j].eof,
                 exp_win(200, 2 + j / 3, 2 + j % 3), j == 5);
      else pass_cnt++;
    end
  endtask

  task automatic test_mid_reset();
    win_ready = 1'b1;
    for (int i = 0; i < 14; i++) push(i, i == 0);
    rst = 1'b1;
    #1;
    check_cnt++;
    if (win_valid !== 1'b0) $display("FAIL mr_win_valid got=%b exp=0", win_valid);
    else pass_cnt++;
    check_cnt++;
    if (win_eof !== 1'b0) $display("FAIL mr_win_eof got=%b exp=0", win_eof);
    else pass_cnt++;
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    got.delete();
    for (int i = 0; i < 20; i++) push(i, 1'b0);
    drain();
    check_cnt++;
    if (got.size() !== 6) $display("FAIL mr_count got=%0d exp=6", got.size());
    else pass_cnt++;
    for (int j = 0; j < 6 && j < got.size(); j++) begin
      check_cnt++;
      if (got[j].d !== exp_win(0, 2 + j / 3, 2 + j % 3) || got[j].eof !== (j == 5))
        $display("FAIL mr_win%0d data=%h eof=%b exp data=%h eof=%b", j, got[j].d, got[j].eof,
                 exp_win(0, 2 + j / 3, 2 + j % 3), j == 5);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_back_to_back();
    test_sof_abort();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout time=%0t limit=500000", $time);
    $fatal(1);
  end

endmodule
